uart_tx_packet_arbiter: RTL and testbench
=========================================

Name: uart_tx_packet_arbiter

Overview:
- Shares one UART transmit byte stream between NUM_REQ requesters (e.g. debug console, Ethernet frame dumper, key loader).
- Arbitration is packet-level round-robin. A grant is held from a requester's first byte until its last byte. A fixed idle gap follows every packet so the host can delimit frames.
- Sits directly upstream of the 12 MBaud fast transmit stream driver, in the 50 MHz domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 16, idle clk cycles inserted after each packet. 0 means no gap.
- MAX_BYTES, 1518, maximum bytes per grant. The grant is force-released after this many bytes.

Ports:
- clk  input  1  system clock (50 MHz).
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a byte presented.
- req_data  input  8*NUM_REQ  byte of requester i at [8*i+:8].
- req_last  input  NUM_REQ  presented byte is the final byte of its packet.
- req_taken  output  NUM_REQ  one-hot, combinational. The presented byte of requester i is consumed this cycle.
- down_ready  input  1  level; downstream can absorb at least two more bytes.
- down_inclk  output  1  registered single-cycle strobe; down_data is valid.
- down_data  output  8  registered byte to the downstream driver.
- grant  output  NUM_REQ  registered one-hot current owner. All zero when none.
- busy  output  1  registered; high in SEND or GAP.
- truncated  output  1  registered single-cycle pulse when a grant is force-released at MAX_BYTES without req_last.

Behaviour:
- Reset (async, active-high) clears the following:
  - state=IDLE, grant=0, busy=0, down_inclk=0, down_data=0, truncated=0.
  - rr_ptr=0, byte_cnt=0, gap_cnt=0.
  - req_taken is combinational and is 0 while in IDLE.
- States are IDLE, SEND and GAP.
- IDLE:
  - If any req_valid is high, select the first i with req_valid[i] high, searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: grant=onehot(i), state=SEND, byte_cnt=0, busy=1.
  - Arbitration latency is 1 cycle. No byte is taken in the arbitration cycle.
- SEND, owner g:
  - take = down_ready && req_valid[g] && !down_inclk. This allows at most one take every 2 cycles.
  - req_taken[g] = take, in the same cycle.
  - Next cycle after a take: down_data = req_data[g], down_inclk = 1, byte_cnt = byte_cnt + 1.
  - Byte latency from take to strobe is exactly 1 cycle.
  - If take happens and (req_last[g] or byte_cnt == MAX_BYTES-1):
    - next cycle: grant=0, rr_ptr=(g+1) mod NUM_REQ;
    - state=GAP, or IDLE if GAP_CYCLES==0; busy is 0 in the IDLE case;
    - truncated=1 for one cycle if req_last[g] was low.
  - req_valid[g] low in SEND: hold the grant indefinitely. There is no timeout. Other requesters stay blocked.
  - Non-granted requesters never see req_taken.
- GAP:
  - gap_cnt counts 0..GAP_CYCLES-1, then state=IDLE, busy=0, gap_cnt=0.
  - down_ready is ignored. req_taken is 0.
- byte_cnt width is clog2(MAX_BYTES)+1 and it never wraps.
- rr_ptr width is clog2(NUM_REQ) and it wraps NUM_REQ-1 -> 0.
- Simultaneous events:
  - Several requesters valid in IDLE: the round-robin pick decides.
  - A new request arriving in GAP waits for IDLE.
  - A requester re-requesting right after its own packet gets lowest priority.
- Reset mid-packet:
  - Immediate abort: the byte strobe in flight is dropped, and no further req_taken is issued.
  - Downstream receives a truncated packet. Requesters must also be reset.

Test Plan:
- Single packet, NUM_REQ=4, GAP_CYCLES=16, down_ready=1: requester 2 presents 0x55,0xAA,0x0F (last).
  - Grant 0100 one cycle after valid.
  - down_data 55,AA,0F on strobes spaced 2 cycles apart.
  - busy low 16 cycles after the last strobe.
- Contention: requesters 0, 1 and 3 each send a 2-byte packet and all assert valid in the same cycle.
  - Packets are output in order 0,1,3.
  - A second round starting with rr_ptr=0 and requesters 1 and 3 valid is ordered 1,3.
- Truncation, MAX_BYTES=4: requester 0 streams 6 bytes without last.
  - Exactly 4 bytes are strobed.
  - truncated pulses once.
  - Requester 0 is re-granted only after the gap and arbitration, starting at byte 5.
- Backpressure: down_ready held low 50 cycles mid-packet.
  - No req_taken and no strobes during the hold.
  - The grant is held.
  - Resumes with the next byte when ready returns, with no loss or duplication.
- Owner stall: the owner drops req_valid for 20 cycles while requester 1 is valid.
  - Requester 1 is never taken until the owner finishes with last.
- Async reset asserted between take and strobe:
  - All outputs go to 0 without waiting for a clk edge.
  - No strobe occurs.
  - After release, IDLE arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/uart_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_packet_arbiter
// Function : Packet-level round-robin arbiter that shares one UART transmit
//            byte stream between NUM_REQ requesters. A grant is held from a
//            packet's first byte to its last byte (or MAX_BYTES), and a fixed
//            idle gap follows every packet so the host can delimit frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_packet_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_BYTES  = 1518
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_taken,
    input  logic                   down_ready,
    output logic                   down_inclk,
    output logic [7:0]             down_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   truncated
);

    // Width of the owner index and round-robin pointer.
    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Byte counter is one bit wider than needed so it can reach MAX_BYTES.
    localparam int c_CNT_W = $clog2(MAX_BYTES) + 1;
    // Gap counter width; kept at least one bit for GAP_CYCLES of 0 or 1.
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_BYTES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST =
        c_GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [NUM_REQ-1:0] c_ONE      = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [c_PTR_W-1:0]   r_owner;
    logic [c_PTR_W-1:0]   r_rr_ptr;
    logic [c_CNT_W-1:0]   r_byte_cnt;
    logic [c_GAP_W-1:0]   r_gap_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_busy;
    logic                 r_down_inclk;
    logic [7:0]           r_down_data;
    logic                 r_truncated;

    logic                 w_pick_valid;
    logic [c_PTR_W-1:0]   w_pick_idx;
    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic [7:0]           w_owner_data;
    logic                 w_take;
    logic                 w_pkt_end;
    logic                 w_gap_done;
    logic [c_PTR_W-1:0]   w_ptr_after_owner;

    // Requester index at a given round-robin distance from the pointer.
    function automatic logic [c_PTR_W-1:0] f_rr_index(
        input logic [c_PTR_W-1:0] base,
        input int                 offset
    );
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return c_PTR_W'(sum);
    endfunction

    // Round-robin search: scanning from the farthest offset back to the
    // pointer lets the nearest valid requester overwrite any farther one.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[f_rr_index(r_rr_ptr, k)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = f_rr_index(r_rr_ptr, k);
            end
        end
    end

    // Owner's presented byte and flags.
    assign w_owner_valid = req_valid[r_owner];
    assign w_owner_last  = req_last[r_owner];
    assign w_owner_data  = req_data[{r_owner, 3'b000} +: 8];

    // A byte is consumed only in SEND, never in the cycle its predecessor
    // is being strobed; this paces the stream at one byte per two clocks.
    assign w_take = (r_state == ST_SEND) && down_ready && w_owner_valid
                    && !r_down_inclk;

    // Packet ends on the requester's last byte or when the grant is full.
    assign w_pkt_end = w_take && (w_owner_last || (r_byte_cnt == c_CNT_LAST));

    assign w_gap_done = (r_gap_cnt == c_GAP_LAST);

    // After a packet the requester following the owner gets first pick.
    assign w_ptr_after_owner = (r_owner == c_PTR_LAST) ? '0 : (r_owner + 1'b1);

    // Consume strobe toward the current owner only.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_taken
        assign req_taken[gi] = w_take && (r_owner == c_PTR_W'(gi));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (w_pkt_end) begin
                    if (GAP_CYCLES > 0) begin
                        w_state_next = ST_GAP;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (w_gap_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output strobe, data byte, status flags and truncation pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_down_inclk <= 1'b0;
            r_down_data  <= 8'h00;
            r_truncated  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_down_inclk <= w_take;
            r_truncated  <= w_pkt_end && !w_owner_last;
            r_busy       <= (w_state_next != ST_IDLE);
            if (w_take) begin
                r_down_data <= w_owner_data;
            end
        end
    end

    // Grant ownership, round-robin pointer and per-grant byte count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner    <= '0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner    <= w_pick_idx;
                        r_grant    <= c_ONE << w_pick_idx;
                        r_byte_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_take) begin
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_pkt_end) begin
                            r_grant  <= '0;
                            r_rr_ptr <= w_ptr_after_owner;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Inter-packet idle counter; only advances while in GAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else if (r_state == ST_GAP) begin
            if (w_gap_done) begin
                r_gap_cnt <= '0;
            end else begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign down_inclk = r_down_inclk;
    assign down_data  = r_down_data;
    assign grant      = r_grant;
    assign busy       = r_busy;
    assign truncated  = r_truncated;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_packet_arbiter
// Function : Scoreboard bench for uart_tx_packet_arbiter. A transaction-level
//            model turns each round of staged packets into the expected byte
//            stream; a monitor pops and compares on every downstream strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_packet_arbiter;

    localparam int NR   = 4;
    localparam int GAP  = 16;
    localparam int MAXB = 4;

    logic              clk;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [8*NR-1:0]   req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_taken;
    logic              down_ready;
    logic              down_inclk;
    logic [7:0]        down_data;
    logic [NR-1:0]     grant;
    logic              busy;
    logic              truncated;

    uart_tx_packet_arbiter #(
        .NUM_REQ    (NR),
        .GAP_CYCLES (GAP),
        .MAX_BYTES  (MAXB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_taken  (req_taken),
        .down_ready (down_ready),
        .down_inclk (down_inclk),
        .down_data  (down_data),
        .grant      (grant),
        .busy       (busy),
        .truncated  (truncated)
    );

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         fin;
        bit         trunc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  stage[NR][$];
    logic [7:0]  bfm_data[NR][$];
    bit          bfm_last[NR][$];
    logic [NR-1:0] stall;
    logic [NR-1:0] taken_s;
    bit          bp_hold;
    bit          bp_rand;
    int          vectors;
    int          miscompares;
    int          cyc;
    int          ptr_m;
    int          strobe_cyc[$];
    bit          gap_on;
    int          gap_n;
    int          tr_cnt;

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Requester models: present the head of each queue, pop on a consumed byte.
    initial begin
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        down_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (!reset && taken_s[i] && bfm_data[i].size() > 0) begin
                    void'(bfm_data[i].pop_front());
                    void'(bfm_last[i].pop_front());
                end
            end
            for (int i = 0; i < NR; i++) begin
                req_valid[i]       = (bfm_data[i].size() > 0) && !stall[i];
                req_data[8*i +: 8] = (bfm_data[i].size() > 0) ? bfm_data[i][0] : 8'h00;
                req_last[i]        = (bfm_last[i].size() > 0) ? bfm_last[i][0] : 1'b0;
            end
            down_ready = bp_hold ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: protocol checks every cycle, scoreboard pop on every strobe.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            taken_s = '0;
            gap_on  = 1'b0;
        end else begin
            taken_s = req_taken;
            check("taken_outside_grant", 32'(req_taken & ~grant), 32'd0);
            if (down_inclk) begin
                strobe_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_strobe: got byte %02h, expected no byte", down_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strobe_data", 32'(down_data), 32'(mon_e.data));
                    check("strobe_truncated", 32'(truncated), 32'(mon_e.trunc));
                    check("strobe_grant", 32'(grant), mon_e.fin ? 32'd0 : (32'd1 << mon_e.id));
                    if (mon_e.fin) begin
                        gap_on = 1'b1;
                        gap_n  = 0;
                    end
                end
            end else if (truncated) begin
                vectors++;
                miscompares++;
                $display("FAIL truncated_without_strobe: got 1, expected 0");
            end
            if (truncated) tr_cnt++;
            if (gap_on) begin
                if (busy) begin
                    gap_n++;
                end else begin
                    check("gap_length", 32'(gap_n), 32'(GAP));
                    gap_on = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic stage_rand(input int id, input int len);
        for (int j = 0; j < len; j++) stage[id].push_back(8'($urandom));
    endtask

    // Reference model: packet-level round robin over the staged packets,
    // splitting any packet longer than MAXB into forced-release chunks.
    task automatic issue_round();
        int   rem[NR];
        int   pos[NR];
        int   total;
        int   sel;
        int   n;
        exp_t e;
        total = 0;
        for (int k = 0; k < NR; k++) begin
            rem[k] = stage[k].size();
            pos[k] = 0;
            total += rem[k];
        end
        while (total > 0) begin
            sel = -1;
            for (int k = 0; k < NR; k++) begin
                if (sel < 0 && rem[(ptr_m + k) % NR] > 0) sel = (ptr_m + k) % NR;
            end
            n = (rem[sel] < MAXB) ? rem[sel] : MAXB;
            for (int j = 0; j < n; j++) begin
                e.id    = sel;
                e.data  = stage[sel][pos[sel] + j];
                e.fin   = (j == n - 1);
                e.trunc = (j == n - 1) && (rem[sel] > n);
                exp_q.push_back(e);
            end
            pos[sel] += n;
            rem[sel] -= n;
            total    -= n;
            ptr_m     = (sel + 1) % NR;
        end
        for (int k = 0; k < NR; k++) begin
            for (int j = 0; j < stage[k].size(); j++) begin
                bfm_data[k].push_back(stage[k][j]);
                bfm_last[k].push_back(j == stage[k].size() - 1);
            end
            stage[k].delete();
        end
    endtask

    function automatic bit bfm_empty();
        for (int k = 0; k < NR; k++) if (bfm_data[k].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && busy === 1'b0 && grant == '0 && bfm_empty() && !gap_on)) begin
            tick();
            n++;
            if (n > 4000) begin
                vectors++;
                miscompares++;
                $display("FAIL round_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), n);
                break;
            end
        end
        tick();
    endtask

    task automatic wait_strobes(input int target);
        int n;
        n = 0;
        while (strobe_cyc.size() < target) begin
            tick();
            n++;
            if (n > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL strobe_timeout: got %0d strobes, expected %0d", strobe_cyc.size(), target);
                break;
            end
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < NR; k++) begin
            bfm_data[k].delete();
            bfm_last[k].delete();
            stage[k].delete();
        end
        exp_q.delete();
        ptr_m = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        clear_all();
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    // Main stimulus sequence.
    initial begin
        int n0;
        int t0;
        int wait_n;
        logic [NR-1:0] mask;
        reset = 1'b1; stall = '0; bp_hold = 1'b0; bp_rand = 1'b0;
        vectors = 0; miscompares = 0; cyc = 0; ptr_m = 0; tr_cnt = 0;
        gap_on = 1'b0; gap_n = 0; taken_s = '0;
        repeat (3) tick();
        check("reset_outputs", 32'({grant, busy, down_inclk, down_data, truncated, req_taken}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_outputs", 32'({grant, busy, down_inclk, truncated, req_taken}), 32'd0);

        // Single packet from requester 2.
        stage[2].push_back(8'h55);
        stage[2].push_back(8'hAA);
        stage[2].push_back(8'h0F);
        n0 = strobe_cyc.size();
        issue_round();
        wait_n = 0;
        while (req_valid == '0 && wait_n < 10) begin
            tick();
            wait_n++;
        end
        check("grant_before_arb", 32'(grant), 32'd0);
        tick();
        check("grant_latency", 32'(grant), 32'b0100);
        check("busy_in_send", 32'(busy), 32'd1);
        wait_done();
        if (strobe_cyc.size() >= n0 + 3) begin
            check("strobe_spacing_1", 32'(strobe_cyc[n0+1] - strobe_cyc[n0]), 32'd2);
            check("strobe_spacing_2", 32'(strobe_cyc[n0+2] - strobe_cyc[n0+1]), 32'd2);
        end else begin
            check("strobe_count", 32'(strobe_cyc.size() - n0), 32'd3);
        end

        // Contention: 0, 1, 3 together from pointer 0, then 1 and 3.
        do_reset();
        stage_rand(0, 2); stage_rand(1, 2); stage_rand(3, 2);
        issue_round();
        wait_done();
        stage_rand(1, 2); stage_rand(3, 2);
        issue_round();
        wait_done();

        // Truncation: six bytes against a four-byte grant limit.
        t0 = tr_cnt;
        stage_rand(0, 6);
        issue_round();
        wait_done();
        check("truncated_pulses", 32'(tr_cnt - t0), 32'd1);

        // Backpressure held for 50 cycles mid-packet.
        stage_rand(2, 4);
        n0 = strobe_cyc.size();
        issue_round();
        wait_strobes(n0 + 1);
        bp_hold = 1'b1;
        repeat (50) begin
            tick();
            check("backpressure_hold", 32'({req_taken, down_inclk, grant}), 32'({4'b0000, 1'b0, 4'b0100}));
        end
        bp_hold = 1'b0;
        wait_done();

        // Owner stall: requester 1 must wait for the owner's last byte.
        do_reset();
        stage_rand(0, 3); stage_rand(1, 2);
        n0 = strobe_cyc.size();
        issue_round();
        wait_strobes(n0 + 1);
        stall[0] = 1'b1;
        repeat (20) begin
            tick();
            check("owner_stall", 32'({req_taken, down_inclk, grant}), 32'({4'b0000, 1'b0, 4'b0001}));
        end
        stall[0] = 1'b0;
        wait_done();

        // Asynchronous reset between a take and its strobe.
        stage_rand(2, 1);
        issue_round();
        wait_done();
        stage_rand(0, 2);
        issue_round();
        wait_n = 0;
        while (req_taken[0] !== 1'b1 && wait_n < 20) begin
            tick();
            wait_n++;
        end
        check("take_before_reset", 32'(req_taken), 32'b0001);
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'({grant, busy, down_inclk, down_data, truncated, req_taken}), 32'd0);
        clear_all();
        repeat (3) begin
            tick();
            check("no_strobe_in_reset", 32'({down_inclk, truncated}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        stage_rand(3, 2); stage_rand(1, 2);
        issue_round();
        wait_done();

        // Randomized rounds with random downstream readiness.
        bp_rand = 1'b1;
        for (int r = 0; r < 25; r++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                if (mask[i]) stage_rand(i, $urandom_range(1, 7));
            end
            issue_round();
            wait_done();
        end
        bp_rand = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
